// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame constants
// and the clock-to-baud divider computation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned DATA_BITS = 8;

   function automatic int unsigned clks_per_bit(input int unsigned clk_mhz,
                                                input int unsigned baud);
      return (clk_mhz * 32'd1_000_000) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO with a registered head word; a pop and a
// push in the same cycle are both honoured even when full.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_c,
   output logic                     empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    rd_next_c;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             do_push_c, do_pop_c;

   assign empty_c   = (count_q == '0);
   assign full_c    = (count_q == CW'(DEPTH));
   assign do_pop_c  = pop_i && !empty_c;
   assign do_push_c = push_i && (!full_c || do_pop_c);
   assign rd_next_c = rd_ptr_q + AW'(1);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_next_c;
      case ({do_push_c, do_pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // The incoming word becomes head when nothing older remains in storage
      if (do_push_c && (empty_c || (do_pop_c && count_q == CW'(1)))) begin
         head_d = wdata_i;
      end else if (do_pop_c && count_q > CW'(1)) begin
         head_d = mem_q[rd_next_c];
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk_i) begin
      if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   assign rdata_o = head_q;
   assign valid_o = valid_q;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd_i, recovers bytes mid-bit and queues
// them in a FIFO with sticky overrun / framing-error flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_MHZ = 100,
   parameter int unsigned BAUD_RATE    = 1000000,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rxd_i,
   input  logic                          rd_en_i,
   input  logic                          clr_err_i,
   output logic [7:0]                    data_o,
   output logic                          valid_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          overrun_o,
   output logic                          frame_err_o
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_MHZ, BAUD_RATE);
   localparam int unsigned HALF         = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W        = $clog2(DATA_BITS);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
   end

   logic                 sync1_q, sync2_q, rx_s;
   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 armed_q, armed_d;
   logic                 overrun_q, overrun_d;
   logic                 frame_err_q, frame_err_d;
   logic                 push_c, pop_c, set_ovr_c, set_fe_c, bit_end_c;
   logic                 fifo_full_c, fifo_empty_c;

   assign rx_s      = sync2_q;
   assign bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign pop_c     = rd_en_i && !fifo_empty_c;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      armed_d   = armed_q;
      push_c    = 1'b0;
      set_ovr_c = 1'b0;
      set_fe_c  = 1'b0;
      case (state_q)
         // Arm only once the line has been seen idle, so a held break is one event
         IDLE: begin
            if (armed_q && !rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end else if (rx_s) begin
               armed_d = 1'b1;
            end
         end
         START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
                  armed_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + BIT_W'(1);
               if (bit_idx_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end_c) begin
               state_d = IDLE;
               armed_d = 1'b0;
               cnt_d   = '0;
               if (!rx_s) begin
                  set_fe_c = 1'b1;
               end else if (fifo_full_c && !rd_en_i) begin
                  set_ovr_c = 1'b1;
               end else begin
                  push_c = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // A new error event takes priority over a simultaneous clear
      overrun_d   = set_ovr_c || (overrun_q && !clr_err_i);
      frame_err_d = set_fe_c  || (frame_err_q && !clr_err_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         armed_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= rxd_i;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         armed_q     <= armed_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_c),
      .wdata_i (shreg_q),
      .pop_i   (pop_c),
      .rdata_o (data_o),
      .valid_o (valid_o),
      .count_o (count_o),
      .full_c  (fifo_full_c),
      .empty_c (fifo_empty_c)
   );

   assign overrun_o   = overrun_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames at 100 clocks/bit and checks received
// bytes against a queue of expected values plus flag/count behaviour.
module tb_uart_rx;

   localparam int unsigned CPB = 100;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       rxd_i;
   logic       rd_en_i;
   logic       clr_err_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic [4:0] count_o;
   logic       overrun_o;
   logic       frame_err_o;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   uart_rx #(
      .CLK_FREQ_MHZ (100),
      .BAUD_RATE    (1000000),
      .FIFO_DEPTH   (16)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rxd_i       (rxd_i),
      .rd_en_i     (rd_en_i),
      .clr_err_i   (clr_err_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .count_o     (count_o),
      .overrun_o   (overrun_o),
      .frame_err_o (frame_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Frame starts one edge after the call; returns just after the stop bit ends
   task automatic send_byte(input logic [7:0] b, input logic stop, input logic exp_push);
      if (exp_push) exp_q.push_back(b);
      @(posedge clk_i); #1 rxd_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk_i);
         #1 rxd_i = b[i];
      end
      repeat (CPB) @(posedge clk_i);
      #1 rxd_i = stop;
      repeat (CPB) @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_clr();
      clr_err_i = 1'b1;
      @(posedge clk_i); #1 clr_err_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int         guard;
      logic [7:0] e;
      guard = 0;
      while (valid_o && guard < 40) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_extra: got byte %h, expected none", name, data_o);
         end else begin
            e = exp_q.pop_front();
            if (data_o !== e) begin
               n_err++;
               $display("FAIL %s_data: got %h expected %h", name, data_o, e);
            end
         end
         rd_en_i = 1'b1;
         @(posedge clk_i); #1 rd_en_i = 1'b0;
         guard++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_missing: got %0d bytes outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; rxd_i = 1'b1; rd_en_i = 1'b0; clr_err_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      n_cmp++;
      if ({data_o, valid_o, count_o, overrun_o, frame_err_o} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got data=%h valid=%b count=%0d ovr=%b fe=%b expected all 0",
                  data_o, valid_o, count_o, overrun_o, frame_err_o);
      end
      rst_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
   endtask

   task automatic test_single_byte();
      int lat;
      lat = 0;
      fork
         send_byte(8'h55, 1'b1, 1'b1);
         begin
            @(posedge clk_i);
            do begin
               @(posedge clk_i);
               lat++;
               #1;
            end while (!valid_o && lat < 3000);
         end
      join
      n_cmp++;
      if (lat < 950 || lat > 954) begin
         n_err++;
         $display("FAIL single_latency: got %0d cycles expected 952+-2", lat);
      end
      n_cmp++;
      if (data_o !== 8'h55 || valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL single_data: got data=%h valid=%b expected 55/1", data_o, valid_o);
      end
      n_cmp++;
      if (count_o !== 5'd1 || overrun_o !== 1'b0 || frame_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL single_status: got count=%0d ovr=%b fe=%b expected 1/0/0",
                  count_o, overrun_o, frame_err_o);
      end
      void'(exp_q.pop_front());
      rd_en_i = 1'b1;
      @(posedge clk_i); #1 rd_en_i = 1'b0;
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL single_pop: got valid=%b expected 0", valid_o);
      end
   endtask

   task automatic test_burst();
      send_byte(8'h00, 1'b1, 1'b1);
      send_byte(8'hFF, 1'b1, 1'b1);
      send_byte(8'hA5, 1'b1, 1'b1);
      n_cmp++;
      if (count_o !== 5'd3 || overrun_o !== 1'b0 || frame_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL burst_status: got count=%0d ovr=%b fe=%b expected 3/0/0",
                  count_o, overrun_o, frame_err_o);
      end
      drain("burst");
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1, (i <= 16));
      n_cmp++;
      if (count_o !== 5'd16 || overrun_o !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_set: got count=%0d ovr=%b expected 16/1", count_o, overrun_o);
      end
      pulse_clr();
      n_cmp++;
      if (overrun_o !== 1'b0 || count_o !== 5'd16) begin
         n_err++;
         $display("FAIL overrun_clear: got ovr=%b count=%0d expected 0/16", overrun_o, count_o);
      end
   endtask

   // FIFO is still full from test_overrun; pop lands on the stop-bit push cycle
   task automatic test_overrun_avoided();
      logic [7:0] e;
      fork
         send_byte(8'h12, 1'b1, 1'b0);
         begin
            @(posedge clk_i);
            repeat (952) @(posedge clk_i);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (data_o !== e) begin
               n_err++;
               $display("FAIL avoid_head: got %h expected %h", data_o, e);
            end
            rd_en_i = 1'b1;
            @(posedge clk_i); #1 rd_en_i = 1'b0;
         end
      join
      exp_q.push_back(8'h12);
      n_cmp++;
      if (count_o !== 5'd16 || overrun_o !== 1'b0) begin
         n_err++;
         $display("FAIL avoid_status: got count=%0d ovr=%b expected 16/0", count_o, overrun_o);
      end
      drain("avoid");
   endtask

   task automatic test_framing_break();
      send_byte(8'h3C, 1'b0, 1'b0);
      n_cmp++;
      if (frame_err_o !== 1'b1 || valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL frame_set: got fe=%b valid=%b expected 1/0", frame_err_o, valid_o);
      end
      pulse_clr();
      repeat (3000) @(posedge clk_i);
      #1;
      n_cmp++;
      if (frame_err_o !== 1'b0 || valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL break_quiet: got fe=%b valid=%b expected 0/0", frame_err_o, valid_o);
      end
      rxd_i = 1'b1;
      repeat (200) @(posedge clk_i);
      send_byte(8'h42, 1'b1, 1'b1);
      n_cmp++;
      if (frame_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL break_recover_fe: got %b expected 0", frame_err_o);
      end
      drain("break");
   endtask

   task automatic test_glitch();
      @(posedge clk_i); #1 rxd_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #1 rxd_i = 1'b1;
      repeat (1200) @(posedge clk_i);
      #1;
      n_cmp++;
      if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
         n_err++;
         $display("FAIL glitch: got valid=%b fe=%b expected 0/0", valid_o, frame_err_o);
      end
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'h99, 1'b1, 1'b1);
      send_byte(8'h3C, 1'b0, 1'b0);
      rxd_i = 1'b1;
      repeat (200) @(posedge clk_i);
      #1;
      n_cmp++;
      if (valid_o !== 1'b1 || frame_err_o !== 1'b1 || data_o !== 8'h99) begin
         n_err++;
         $display("FAIL rst_pre: got valid=%b fe=%b data=%h expected 1/1/99",
                  valid_o, frame_err_o, data_o);
      end
      @(posedge clk_i); #1 rxd_i = 1'b0;
      repeat (400) @(posedge clk_i);
      #1 rst_i = 1'b1;
      #2;
      n_cmp++;
      if ({data_o, valid_o, count_o, overrun_o, frame_err_o} !== 16'h0) begin
         n_err++;
         $display("FAIL rst_async: got data=%h valid=%b count=%0d ovr=%b fe=%b expected all 0",
                  data_o, valid_o, count_o, overrun_o, frame_err_o);
      end
      exp_q.delete();
      rxd_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1 rst_i = 1'b0;
      repeat (50) @(posedge clk_i);
      send_byte(8'hC3, 1'b1, 1'b1);
      n_cmp++;
      if (count_o !== 5'd1 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_after: got count=%0d fe=%b ovr=%b expected 1/0/0",
                  count_o, frame_err_o, overrun_o);
      end
      drain("rst");
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_burst();
      test_overrun();
      test_overrun_avoided();
      test_framing_break();
      test_glitch();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
